// File: rtl/arb_mux_if.sv
// Valid/ready bundle between NUM_CH requestors and one shared sink.
// The slave modport is the arbiter's view; master is the requestor/sink side.
interface arb_mux_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) ();

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

endinterface

// File: rtl/arb_mux.sv
// Arbitrating N:1 valid/ready mux with a one-deep registered output stage.
// RR_MODE=0 picks the lowest requesting index; RR_MODE=1 rotates after the last winner.
module arb_mux #(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input logic      clk,
  input logic      rst_n,
  arb_mux_if.slave bus
);

  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic              load_en_s;
  logic              found_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [SEL_W-1:0]  idx_s;
  logic [NUM_CH-1:0] grant_s;
  logic [WIDTH-1:0]  ch_data_s [NUM_CH];
  int                raw_s;

  // Unpack channel words so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data_s[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Walk the search order backwards so the earliest requester in that order is the last to write.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    raw_s       = 0;
    idx_s       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      raw_s       = (RR_MODE != 0) ? (int'(last_grant_q) + 1 + k) : k;
      idx_s       = SEL_W'((raw_s >= NUM_CH) ? (raw_s - NUM_CH) : raw_s);
      found_s     = found_s | bus.in_valid[idx_s];
      grant_idx_s = bus.in_valid[idx_s] ? idx_s : grant_idx_s;
    end
  end

  assign grant_s      = found_s ? (ONE_HOT0 << grant_idx_s) : '0;
  assign load_en_s    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (rst_n && load_en_s) ? grant_s : '0;

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (load_en_s && found_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = ch_data_s[grant_idx_s];
      out_sel_d    = grant_idx_s;
      last_grant_d = (RR_MODE != 0) ? grant_idx_s : last_grant_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any held word and restarts the rotation at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= LAST_CH;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
